// File: rtl/local_flit_injector.sv
// Network-interface flit transmitter: turns one packet descriptor plus a body payload
// stream into HEAD/BODY/TAIL (or HEADTAIL) flits on a single VC chosen at packet start.
package noc_params;
    localparam int VC_NUM            = 2;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int ADDR_NETWORK      = 2;
    localparam int DEST_ADDR_SIZE_X  = 2;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - ADDR_NETWORK
                                       - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        logic [ADDR_NETWORK-1:0]      sub_network;
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;
endpackage

module local_flit_injector
    import noc_params::*;
#(
    parameter int MAX_LEN = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [ADDR_NETWORK-1:0]      pkt_sub_network_i,
    input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
    input  logic [LEN_W-1:0]             pkt_len_i,
    input  logic                         pl_valid_i,
    input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
    output logic                         pl_ready_o,
    input  logic [VC_NUM-1:0]            on_off_i,
    input  logic [VC_NUM-1:0]            is_allocatable_i,
    output logic [$bits(flit_t)-1:0]     flit_o,
    output logic                         flit_valid_o,
    output logic                         busy_o,
    output logic [1:0]                   dbg_state_o
);
    // Handshakes: a descriptor or payload word transfers on a rising edge where its
    // valid and ready are both high; ready never depends on the matching valid.

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALLOC = 2'b01,
        SEND  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [VC_SIZE-1:0] vc_q, vc_d;
    head_data_t       head_q, head_d;
    flit_t            flit_q, flit_d;
    logic             flit_valid_q, flit_valid_d;

    logic               alloc_found;
    logic [VC_SIZE-1:0] alloc_vc;
    logic [LEN_W-1:0]   len_clamped;

    // Descending scan so the lowest eligible VC index wins.
    always_comb begin
        alloc_found = 1'b0;
        alloc_vc    = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (is_allocatable_i[v] && on_off_i[v]) begin
                alloc_found = 1'b1;
                alloc_vc    = VC_SIZE'(v);
            end
        end
    end

    assign len_clamped = (pkt_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pkt_len_i;

    assign pkt_ready_o  = (state_q == IDLE) && !rst;
    assign pl_ready_o   = (state_q == SEND) && on_off_i[vc_q] && !rst;
    assign flit_o       = flit_q;
    assign flit_valid_o = flit_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        vc_d         = vc_q;
        head_d       = head_q;
        flit_d       = flit_q;
        flit_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pkt_valid_i) begin
                    head_d.sub_network = pkt_sub_network_i;
                    head_d.x_dest      = pkt_x_dest_i;
                    head_d.y_dest      = pkt_y_dest_i;
                    head_d.head_pl     = pkt_head_pl_i;
                    rem_d              = len_clamped;
                    state_d            = ALLOC;
                end
            end
            ALLOC: begin
                if (alloc_found) begin
                    flit_d.flit_label     = (rem_q == '0) ? HEADTAIL : HEAD;
                    flit_d.vc_id          = alloc_vc;
                    flit_d.data.head_data = head_q;
                    flit_valid_d          = 1'b1;
                    vc_d                  = alloc_vc;
                    state_d               = (rem_q == '0) ? IDLE : SEND;
                end
            end
            SEND: begin
                if (on_off_i[vc_q] && pl_valid_i) begin
                    flit_d.flit_label = (rem_q == LEN_W'(1)) ? TAIL : BODY;
                    flit_d.vc_id      = vc_q;
                    flit_d.data.bt_pl = pl_data_i;
                    flit_valid_d      = 1'b1;
                    rem_d             = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            vc_q         <= '0;
            head_q       <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            vc_q         <= vc_d;
            head_q       <= head_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
        end
    end

endmodule
